// File: rtl/kronos_types.sv
// Shared Kronos types: machine timer register offsets, ctrl layout
// and the byte-lane merge used by the timer's masked writes.
package kronos_types;

  localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_CTRL        = 3'd4;

  typedef struct packed {
    logic [30:0] rsvd;
    logic        enable;
  } mtimer_ctrl_t;

  function automatic logic [31:0] mtimer_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  mask
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kronos_machine_timer_if.sv
// Data-bus req/ack slave port of the machine timer.
// Master drives the request fields; slave returns ack and read data.
interface kronos_machine_timer_if;

  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;

  modport master (
    output data_addr, data_wr_data, data_mask,
    output data_wr_en, data_req,
    input  data_ack, data_rd_data
  );

  modport slave (
    input  data_addr, data_wr_data, data_mask,
    input  data_wr_en, data_req,
    output data_ack, data_rd_data
  );

endinterface

// File: rtl/kronos_timer_counter64.sv
// 64-bit tick counter with per-half masked writes.
// A write to either half takes priority over the increment.
module kronos_timer_counter64
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  logic        tick,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= mtimer_merge(count[31:0], wr_data, wr_mask);
    end else if (wr_hi) begin
      count[63:32] <= mtimer_merge(count[63:32], wr_data, wr_mask);
    end else if (tick) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/kronos_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) as a req/ack data-bus slave.
// Raises timer_interrupt while mtime >= mtimecmp.
module kronos_machine_timer
  import kronos_types::*;
#(
  parameter int unsigned TICK_DIV = 1
)(
  input  logic                  clk,
  input  logic                  rstz,
  kronos_machine_timer_if.slave bus,
  output logic                  timer_interrupt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic         ack_q;
  logic [31:0]  rd_q;
  logic [31:0]  cmp_lo;
  logic [31:0]  cmp_hi;
  mtimer_ctrl_t ctrl;
  logic [PW-1:0] presc;
  logic         irq_q;
  logic [63:0]  mtime;
  logic [31:0]  rd_mux;
  logic [2:0]   off;
  logic         sample;
  logic         wr;
  logic         tick;
  logic         unused_addr;

  assign off    = bus.data_addr[4:2];
  assign sample = bus.data_req & ~ack_q;
  assign wr     = sample & bus.data_wr_en;
  assign tick   = ctrl.enable & (presc == PRE_MAX);

  assign unused_addr =
    ^{bus.data_addr[31:5], bus.data_addr[1:0]};

  assign bus.data_ack     = ack_q;
  assign bus.data_rd_data = rd_q;
  assign timer_interrupt  = irq_q;

  kronos_timer_counter64 u_mtime (
    .clk     (clk),
    .rstz    (rstz),
    .tick    (tick),
    .wr_lo   (wr && off == MTIMER_MTIME_LO
              && |bus.data_mask),
    .wr_hi   (wr && off == MTIMER_MTIME_HI
              && |bus.data_mask),
    .wr_data (bus.data_wr_data),
    .wr_mask (bus.data_mask),
    .count   (mtime)
  );

  always_comb begin
    rd_mux = '0;
    case (off)
      MTIMER_MTIME_LO:    rd_mux = mtime[31:0];
      MTIMER_MTIME_HI:    rd_mux = mtime[63:32];
      MTIMER_MTIMECMP_LO: rd_mux = cmp_lo;
      MTIMER_MTIMECMP_HI: rd_mux = cmp_hi;
      MTIMER_CTRL:        rd_mux = {31'd0, ctrl.enable};
      default:            rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ack_q  <= 1'b0;
      rd_q   <= '0;
      cmp_lo <= '1;
      cmp_hi <= '1;
      ctrl   <= '{rsvd: '0, enable: 1'b1};
      presc  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack_q <= sample;
      if (sample && !bus.data_wr_en) rd_q <= rd_mux;
      if (wr && off == MTIMER_MTIMECMP_LO)
        cmp_lo <= mtimer_merge(cmp_lo, bus.data_wr_data,
                               bus.data_mask);
      if (wr && off == MTIMER_MTIMECMP_HI)
        cmp_hi <= mtimer_merge(cmp_hi, bus.data_wr_data,
                               bus.data_mask);
      if (wr && off == MTIMER_CTRL && bus.data_mask[0])
        ctrl.enable <= bus.data_wr_data[0];
      if (ctrl.enable) presc <= tick ? '0 : presc + PW'(1);
      irq_q <= mtime >= {cmp_hi, cmp_lo};
    end
  end

endmodule

// File: tb/tb_kronos_machine_timer.sv
// Directed bench for kronos_machine_timer: one instance per TICK_DIV
// (1 and 4), shared clock and reset.
module tb_kronos_machine_timer;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  logic irq1, irq4;
  int checks = 0;
  int failures = 0;

  kronos_machine_timer_if m1 ();
  kronos_machine_timer_if m4 ();

  kronos_machine_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rstz(rstz), .bus(m1), .timer_interrupt(irq1)
  );

  kronos_machine_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rstz(rstz), .bus(m4), .timer_interrupt(irq4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req,
                       input logic wr, input logic [31:0] addr,
                       input logic [31:0] data,
                       input logic [3:0] mask);
    if (sel == 0) begin
      m1.data_req = req;  m1.data_wr_en = wr;
      m1.data_addr = addr; m1.data_wr_data = data;
      m1.data_mask = mask;
    end else begin
      m4.data_req = req;  m4.data_wr_en = wr;
      m4.data_addr = addr; m4.data_wr_data = data;
      m4.data_mask = mask;
    end
  endtask

  task automatic xfer(input int sel, input logic wr,
                      input logic [31:0] addr,
                      input logic [31:0] data,
                      input logic [3:0] mask,
                      output logic [31:0] rd);
    int n;
    logic a;
    n = 0;
    drive(sel, 1'b1, wr, addr, data, mask);
    do begin
      @(posedge clk); #1;
      n++;
      a = (sel == 0) ? m1.data_ack : m4.data_ack;
    end while (a !== 1'b1 && n < 4);
    chk("xfer_ack", a, 1);
    rd = (sel == 0) ? m1.data_rd_data : m4.data_rd_data;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    logic [31:0] rd, v1, v2, h1, h2;
    logic [5:0] pat;

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #12;
    chk("rst_ack", m1.data_ack, 0);
    chk("rst_rd", m1.data_rd_data, 0);
    chk("rst_irq", irq1, 0);
    #9 rstz = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    xfer(0, 0, 32'h0, 0, 0, rd);
    chk("mtime_after_10", rd, 32'h0000_000A);
    xfer(0, 0, 32'h10, 0, 0, rd);
    chk("ctrl_reset", rd, 1);
    chk("irq_idle", irq1, 0);

    // rollover: carry into the high half
    xfer(0, 1, 32'h0, 32'hFFFF_FFFE, 4'hF, rd);
    xfer(0, 1, 32'h4, 32'h0000_0005, 4'hF, rd);
    xfer(0, 0, 32'h4, 0, 0, h1);
    xfer(0, 0, 32'h0, 0, 0, v1);
    xfer(0, 0, 32'h4, 0, 0, h2);
    chk("roll_hi1", h1, 32'h6);
    chk("roll_lo", v1, 32'h2);
    chk("roll_hi2", h2, 32'h6);

    // compare and interrupt timing
    xfer(0, 1, 32'h0C, 32'h0, 4'hF, rd);
    xfer(0, 1, 32'h08, 32'h40, 4'hF, rd);
    xfer(0, 1, 32'h04, 32'h0, 4'hF, rd);
    xfer(0, 1, 32'h00, 32'h0, 4'hF, rd);
    repeat (64) @(posedge clk);
    #1;
    chk("irq_before", irq1, 0);
    @(posedge clk); #1;
    chk("irq_rise", irq1, 1);
    xfer(0, 1, 32'h08, 32'h1000, 4'hF, rd);
    chk("irq_hold", irq1, 1);
    @(posedge clk); #1;
    chk("irq_clear", irq1, 0);

    // masked writes
    xfer(0, 1, 32'h08, 32'h0, 4'hF, rd);
    xfer(0, 1, 32'h08, 32'hAABB_CCDD, 4'b0101, rd);
    xfer(0, 0, 32'h08, 0, 0, rd);
    chk("mask_0101", rd, 32'h00BB_00DD);
    xfer(0, 1, 32'h08, 32'h1234_5678, 4'b0000, rd);
    xfer(0, 0, 32'h08, 0, 0, rd);
    chk("mask_0", rd, 32'h00BB_00DD);
    xfer(0, 0, 32'h0C, 0, 0, rd);
    chk("cmp_hi", rd, 32'h0);

    // back-to-back requests
    @(posedge clk); #1;
    pat = '0;
    drive(0, 1'b1, 1'b0, 32'hFFFF_FF1C, 32'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat = {pat[4:0], m1.data_ack};
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("ack_pattern", pat, 6'b101010);
    chk("unmapped_rd", m1.data_rd_data, 0);
    xfer(0, 0, 32'h8000_0010, 0, 0, rd);
    chk("ctrl_hi_addr", rd, 1);

    // collision: write wins over the tick
    xfer(0, 1, 32'h0, 32'h1234_0000, 4'hF, rd);
    xfer(0, 0, 32'h0, 0, 0, rd);
    chk("collision", rd, 32'h1234_0001);

    // prescaler, TICK_DIV=4
    xfer(1, 0, 32'h0, 0, 0, v1);
    repeat (39) @(posedge clk);
    #1;
    xfer(1, 0, 32'h0, 0, 0, v2);
    chk("div4_rate", v2 - v1, 10);
    xfer(1, 1, 32'h10, 32'h0, 4'hF, rd);
    xfer(1, 0, 32'h10, 0, 0, rd);
    chk("ctrl_off", rd, 0);
    xfer(1, 0, 32'h0, 0, 0, v1);
    repeat (20) @(posedge clk);
    #1;
    xfer(1, 0, 32'h0, 0, 0, v2);
    chk("frozen", v2, v1);
    xfer(1, 1, 32'h0, 32'hCAFE_BABE, 4'hF, rd);
    xfer(1, 0, 32'h0, 0, 0, rd);
    chk("frozen_wr", rd, 32'hCAFE_BABE);
    xfer(1, 1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
    xfer(1, 0, 32'h10, 0, 0, rd);
    chk("ctrl_rsvd", rd, 1);
    xfer(1, 0, 32'h0, 0, 0, v1);
    repeat (39) @(posedge clk);
    #1;
    xfer(1, 0, 32'h0, 0, 0, v2);
    chk("resume_rate", v2 - v1, 10);
    chk("resume_base", v1 - 32'hCAFE_BABE < 4, 1);

    // reset in the middle of a transaction
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    @(posedge clk); #1;
    chk("pre_rst_ack", m1.data_ack, 1);
    #2 rstz = 1'b0;
    #1;
    chk("rst_mid_ack", m1.data_ack, 0);
    chk("rst_mid_rd", m1.data_rd_data, 0);
    @(posedge clk); #1;
    rstz = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", m1.data_ack, 1);
    chk("post_rst_rd", m1.data_rd_data, 1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kronos_machine_timer.md
Name: kronos_machine_timer

Overview:
Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the core's data bus.
- Maintains a 64-bit free-running mtime and a 64-bit mtimecmp, both accessible as 32-bit halves.
- Drives the timer_interrupt input of the write-back stage.
- Slave side of the same req/ack data bus protocol the write-back stage masters.

Parameters:
TICK_DIV, 1, clocks per mtime increment (>=1); 1 means increment every enabled cycle.

Ports:
clk  in  1  core clock
rstz  in  1  asynchronous active-low reset
data_addr  in  32  byte address; only data_addr[4:2] is decoded, other bits are ignored
data_wr_data  in  32  write data
data_mask  in  4  byte enables for writes
data_wr_en  in  1  1=write, 0=read
data_req  in  1  transaction request, held until ack
data_ack  out  1  one-cycle completion pulse
data_rd_data  out  32  read data, valid when data_ack=1
timer_interrupt  out  1  level interrupt: mtime >= mtimecmp

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low (rstz).
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl.enable=1, prescaler=0.
  - data_ack=0, data_rd_data=0, timer_interrupt=0.
- Register map (data_addr[4:2]):
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
  - 4: ctrl; bit0=enable, bits[31:1] read 0 and ignore writes.
  - 5-7: unmapped; reads return 0, writes are ignored, the transaction is still acked.
- Handshake:
  - data_ack <= data_req & ~data_ack (registered). Each request acks exactly 1 cycle after it is first sampled, so at most one ack per 2 cycles.
  - The master may keep req high after the ack cycle to issue the next transaction.
  - The sampled address, write data, mask and wr_en are the values present in the cycle req is sampled with ack low.
- Reads:
  - data_rd_data is registered alongside data_ack and holds the register value at the sample edge (pre-update).
  - data_rd_data holds its value when ack=0.
- Writes:
  - Committed at the sample edge, i.e. the same edge that raises data_ack.
  - Bytes are written per data_mask; unmasked bytes keep their value.
  - mask=0 completes the transaction with no change.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1; tick when it equals TICK_DIV-1, then wraps to 0.
  - Held at current value when enable=0.
  - Not affected by mtime writes.
- Increment:
  - On tick, mtime <= mtime+1 as a 64-bit add; the low-half carry propagates into the high half.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write/tick collision:
  - A write to either mtime half in a tick cycle wins.
  - The written half takes the masked data; the other half keeps its old value; no increment that cycle.
- Interrupt:
  - timer_interrupt <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - It therefore reflects an update one cycle after the update lands.
  - It is level-sensitive and clears only by raising mtimecmp or writing mtime lower.
- Split-access race:
  - Software reads hi/lo/hi and retries on mismatch; no hardware latching of halves.
- Reset mid-transaction:
  - A pending req is abandoned and data_ack=0 immediately.
  - After reset, a still-high req is treated as new.

Decomposition:
- Shared package kronos_types gains:
  - Word-offset constants MTIMER_MTIME_LO=3'd0, MTIMER_MTIME_HI=3'd1, MTIMER_MTIMECMP_LO=3'd2, MTIMER_MTIMECMP_HI=3'd3, MTIMER_CTRL=3'd4.
  - A typedef for the ctrl register.
- One sub-module, kronos_timer_counter64:
  - 64-bit counter with tick input, split per-half masked write and carry.
  - Instantiated once for mtime; mtimecmp is plain registers.

Test Plan:
- Reset release, TICK_DIV=1, no writes → mtime reads 0x0000000A±1 after 10 cycles; read of 0x10 returns 1; timer_interrupt=0.
- Rollover: write mtime_lo=FFFF_FFFE, mtime_hi=0000_0005, wait 3 ticks → hi/lo/hi reads give 0000_0006 / 0000_000x with hi consistent; no lost carry.
- Compare: mtimecmp_hi=0, mtimecmp_lo=0x40, mtime=0 → timer_interrupt rises exactly 1 cycle after mtime reaches 0x40; writing mtimecmp_lo=0x1000 clears it 1 cycle later.
- Masked write: mtimecmp_lo=0, write 0xAABBCCDD with mask 4'b0101 → reads 0x00BB00DD; mask 0 → unchanged, still acked.
- Handshake: req held high for 6 cycles of reads → exactly 3 ack pulses spaced 2 cycles apart; unmapped offset 0x1C reads 0.
- Enable/prescale (TICK_DIV=4): mtime advances 1 per 4 clocks; write ctrl=0 → mtime frozen over 20 cycles; ctrl=1 resumes. Write collision with tick: written value read back exactly, no +1.
